pipe_stage_buf: RTL

- Parametrised successor to the fixed inter-stage pipeline registers (EX/MEM style).
- Carries a DATA_W-bit datapath payload and a CTRL_W-bit control/write-enable field.
- Adds valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush, and a stall-cycle performance counter.
- Instantiated between any two pipeline stages in place of the hand-written stage registers.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_stage_buf_if.sv | 26 ++
 rtl/pipe_entry.sv | 34 +++
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_buf slice: state encoding, default widths
// and control-field bit positions used at the stage boundaries.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int DATA_W_DEF = 160;
  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  // Control-field layout shared by the EX/MEM and MEM/WB boundaries.
  localparam int W_REGFILES = 0;
  localparam int W_HI       = 1;
  localparam int W_LO       = 2;
  localparam int W_DMEM     = 3;
  localparam int IS_GOTO    = 4;
  localparam int SEL_ALU_LSB = 5;
  localparam int SEL_ALU_W   = 3;
  localparam int SEL_WB_LSB  = 8;
  localparam int SEL_WB_W    = 2;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage-boundary bus: upstream (in_*) and downstream (out_*) handshakes.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_entry.sv
// One data+ctrl holding register with load and clear.
// PIPE_STAGE_DATA_CLR_EN: clear also zeroes the data field, not just ctrl.
module pipe_entry #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
`ifdef PIPE_STAGE_DATA_CLR_EN
      q_data <= '0;
`else
      q_data <= q_data;
`endif
    end else if (load) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid, flush and stall counter.
// Build option PIPE_STAGE_DATA_CLR_EN zeroes payload data whenever an entry is vacated.
//
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   ONE   | head (main) entry valid, skid empty
//   TWO   | head and skid both valid, in_ready=0
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_buf_if.slave  bus,
  input  logic             flush,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e       state, state_nxt;
  logic              in_ready_q, out_valid_q;
  logic              in_fire, out_fire;
  logic              main_ld, main_from_skid, main_clr;
  logic              skid_ld, skid_clr;
  logic [DATA_W-1:0] main_d_data, skid_data;
  logic [CTRL_W-1:0] main_d_ctrl, skid_ctrl;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) begin
          main_ld   = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (out_fire) begin
            main_clr  = 1'b1;
            state_nxt = EMPTY;
          end else if (in_fire) begin
            skid_ld   = 1'b1;
            state_nxt = TWO;
          end
        end
        TWO: if (out_fire) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_nxt      = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : bus.in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_ld),
    .clr    (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_data (bus.out_data),
    .q_ctrl (bus.out_ctrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_ld),
    .clr    (skid_clr),
    .d_data (bus.in_data),
    .d_ctrl (bus.in_ctrl),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
      // Flush cycles are not counted as back-pressure.
      if (stat_clr)
        stall_cnt <= '0;
      else if (out_valid_q && !bus.out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

endmodule
